oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 133 +++++++++++++
 tb/tb_oam_dma.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Sprite-memory DMA engine. A CPU write of a page number to TRIGGER_ADDR
// halts the CPU and copies the 256 bytes of that page, one read/write pair
// at a time, to the fixed DEST_ADDR port. Reads always start on an even
// (parity 0) cycle, so one ALIGN cycle is added when needed.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | bus released, CPU running, waiting for a trigger write
// HALT  | CPU stopped; chooses READ or ALIGN from the cycle parity
// ALIGN | one wait cycle so the following READ lands on parity 0
// READ  | drive source address {page, idx}; byte captured at end of cycle
// WRITE | drive DEST_ADDR with the captured byte; advance idx

module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR    = 16'h2004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_we,
    input  logic [7:0]  dma_din,
    output logic        rdy,
    output logic        dma_busy,
    output logic [15:0] dma_addr,
    output logic        dma_we,
    output logic [7:0]  dma_dout
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state, state_n;
    logic        parity;
    logic [7:0]  page, page_n;
    logic [7:0]  idx, idx_n;
    logic [7:0]  data_q, data_n;
    logic        rdy_n;
    logic        busy_n;
    logic [15:0] addr_n;
    logic        we_n;
    logic [7:0]  dout_n;

    // Free-running even/odd cycle marker used to align the first READ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end

    // State, transfer bookkeeping and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            data_q   <= 8'h00;
            rdy      <= 1'b1;
            dma_busy <= 1'b0;
            dma_addr <= 16'h0000;
            dma_we   <= 1'b0;
            dma_dout <= 8'h00;
        end else begin
            state    <= state_n;
            page     <= page_n;
            idx      <= idx_n;
            data_q   <= data_n;
            rdy      <= rdy_n;
            dma_busy <= busy_n;
            dma_addr <= addr_n;
            dma_we   <= we_n;
            dma_dout <= dout_n;
        end
    end

    // Next-state logic; outputs are decoded from the next state so that the
    // output registers always describe the state currently being occupied.
    always_comb begin
        state_n = state;
        page_n  = page;
        idx_n   = idx;
        data_n  = data_q;

        unique case (state)
            IDLE: begin
                if (cpu_we && (cpu_addr == TRIGGER_ADDR)) begin
                    page_n  = cpu_din;
                    idx_n   = 8'h00;
                    state_n = HALT;
                end
            end
            HALT: begin
                // Parity flips at this edge: odd now means even in the next cycle.
                state_n = parity ? READ : ALIGN;
            end
            ALIGN: begin
                state_n = READ;
            end
            READ: begin
                data_n  = dma_din;
                state_n = WRITE;
            end
            WRITE: begin
                idx_n   = idx + 8'd1;
                state_n = (idx == 8'hFF) ? IDLE : READ;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        rdy_n  = (state_n == IDLE);
        busy_n = (state_n != IDLE);
        we_n   = (state_n == WRITE);
        addr_n = 16'h0000;
        dout_n = dma_dout;
        if (state_n == READ) begin
            addr_n = {page_n, idx_n};
        end else if (state_n == WRITE) begin
            addr_n = DEST_ADDR;
            dout_n = data_n;
        end
    end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a transfer-level reference model predicts every cycle's
// bus outputs from the trigger time, page and cycle parity; a negedge
// process compares the DUT against it, and the stimulus adds literal checks.

module tb_oam_dma;

    localparam logic [15:0] TRIG = 16'h4014;
    localparam logic [15:0] DEST = 16'h2004;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic [7:0]  dma_din;
    logic        rdy;
    logic        dma_busy;
    logic [15:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_dout;

    int n_cmp = 0;
    int n_bad = 0;

    oam_dma #(.TRIGGER_ADDR(TRIG), .DEST_ADDR(DEST)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_we   (cpu_we),
        .dma_din  (dma_din),
        .rdy      (rdy),
        .dma_busy (dma_busy),
        .dma_addr (dma_addr),
        .dma_we   (dma_we),
        .dma_dout (dma_dout)
    );

    always #5 clk = ~clk;

    // Memory contents seen on the bus: a fixed scramble of the address.
    function automatic logic [7:0] bus_byte(input logic [15:0] a);
        return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'hA5;
    endfunction

    // The bus answers for whatever address the DMA is presenting.
    always_comb dma_din = bus_byte(dma_addr);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_cyc = 0;
    bit          m_active = 0;
    int          m_k = 0;
    int          m_len = 0;
    int          m_align = 0;
    logic [7:0]  m_page = 8'h00;
    logic        e_rdy = 1'b1;
    logic        e_busy = 1'b0;
    logic        e_we = 1'b0;
    logic [15:0] e_addr = 16'h0000;
    logic [7:0]  e_dout = 8'h00;

    // A transfer is: cycle 0 HALT, optional ALIGN, then 256 read/write pairs.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc = 0;
            m_active = 0;
            m_k = 0;
        end else begin
            m_cyc++;
            if (m_active) begin
                m_k++;
                if (m_k == m_len) m_active = 0;
            end else if (cpu_we === 1'b1 && cpu_addr == TRIG) begin
                m_active = 1;
                m_k = 0;
                m_page = cpu_din;
                m_align = (m_cyc + 1) % 2;
                m_len = 513 + m_align;
            end
        end
        e_rdy  = !m_active;
        e_busy = m_active;
        e_we   = 1'b0;
        e_addr = 16'h0000;
        if (m_active && m_k >= 1 + m_align) begin
            int j;
            int i;
            j = m_k - 1 - m_align;
            i = j / 2;
            if (j % 2 == 0) begin
                e_addr = {m_page, 8'(i)};
            end else begin
                e_we   = 1'b1;
                e_addr = DEST;
                e_dout = bus_byte({m_page, 8'(i)});
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("rdy", 32'(rdy), 32'(e_rdy));
        chk("dma_busy", 32'(dma_busy), 32'(e_busy));
        chk("dma_we", 32'(dma_we), 32'(e_we));
        chk("dma_addr", 32'(dma_addr), 32'(e_addr));
        if (e_we) chk("dma_dout", 32'(dma_dout), 32'(e_dout));
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic we, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_we = we;
        cpu_addr = a;
        cpu_din = d;
    endtask

    // Call at a negedge. Triggers page pg (optionally on a chosen parity of
    // the trigger cycle), follows the transfer, and returns with the bench at
    // the negedge of the first idle cycle.
    task automatic run_xfer(input logic [7:0] pg, input int want_par,
                            input int inject_at, input logic [15:0] inj_addr,
                            input logic [7:0] inj_din, input int reset_at,
                            output logic [15:0] first_rd, output logic [15:0] last_rd);
        int len;
        int writes;
        int t_par;
        bit done;
        bit injected;
        logic [15:0] prev_addr;
        len = 0;
        writes = 0;
        done = 0;
        injected = 0;
        prev_addr = 16'h0000;
        first_rd = 16'hxxxx;
        last_rd = 16'hxxxx;
        if (want_par >= 0 && (m_cyc % 2) != want_par) @(negedge clk);
        t_par = m_cyc % 2;
        cpu_we = 1'b1;
        cpu_addr = TRIG;
        cpu_din = pg;
        for (int n = 0; n < 700 && !done; n++) begin
            @(negedge clk);
            cpu_we = 1'b0;
            cpu_addr = 16'h0000;
            if (rdy !== 1'b0) begin
                done = 1;
            end else begin
                len++;
                if (dma_we === 1'b1) begin
                    writes++;
                    if (writes == 1) first_rd = prev_addr;
                    last_rd = prev_addr;
                end
                prev_addr = dma_addr;
                if (writes == reset_at) begin
                    #2 reset = 1'b1;
                    #1;
                    chk("abort_rdy", 32'(rdy), 32'd1);
                    chk("abort_we", 32'(dma_we), 32'd0);
                    repeat (2) @(negedge clk);
                    #2 reset = 1'b0;
                    @(negedge clk);
                    return;
                end
                if (writes == inject_at && !injected) begin
                    injected = 1;
                    cpu_we = 1'b1;
                    cpu_addr = inj_addr;
                    cpu_din = inj_din;
                end
            end
        end
        chk("xfer_timeout", 32'(done), 32'd1);
        chk("busy_len", 32'(len), 32'(t_par ? 514 : 513));
        chk("write_count", 32'(writes), 32'd256);
    endtask

    initial begin
        logic [15:0] f_rd;
        logic [15:0] l_rd;
        reset = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 16'h0000;
        cpu_din = 8'h00;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'd1);
        chk("reset_busy", 32'(dma_busy), 32'd0);
        chk("reset_addr", 32'(dma_addr), 32'd0);

        // Non-trigger write and a plain read of the trigger address.
        step(1'b1, 16'h4015, 8'h02);
        step(1'b0, TRIG, 8'h02);
        step(1'b0, 16'h0000, 8'h00);
        repeat (3) @(negedge clk);
        chk("no_trigger_rdy", 32'(rdy), 32'd1);

        // Parity-0 trigger, then immediately a parity-1 trigger.
        run_xfer(8'h02, 0, -1, 16'h0, 8'h0, -1, f_rd, l_rd);
        chk("p0_first_read", 32'(f_rd), 32'h0200);
        chk("p0_last_read", 32'(l_rd), 32'h02FF);
        run_xfer(8'h02, 1, -1, 16'h0, 8'h0, -1, f_rd, l_rd);
        chk("p1_first_read", 32'(f_rd), 32'h0200);
        chk("p1_last_read", 32'(l_rd), 32'h02FF);

        // Trigger on the very first idle cycle.
        run_xfer(8'h41, -1, -1, 16'h0, 8'h0, -1, f_rd, l_rd);
        chk("b2b_first_read", 32'(f_rd), 32'h4100);

        // Retrigger with page 05 after byte 10 is ignored.
        repeat (2) @(negedge clk);
        run_xfer(8'h02, 0, 10, TRIG, 8'h05, -1, f_rd, l_rd);
        chk("retrig_last_read", 32'(l_rd), 32'h02FF);

        // Reset after write #100, then restart with page 03.
        repeat (3) @(negedge clk);
        run_xfer(8'h77, -1, -1, 16'h0, 8'h0, 100, f_rd, l_rd);
        run_xfer(8'h03, -1, -1, 16'h0, 8'h0, -1, f_rd, l_rd);
        chk("restart_first_read", 32'(f_rd), 32'h0300);

        // Top page stays inside the page.
        @(negedge clk);
        run_xfer(8'hFF, -1, -1, 16'h0, 8'h0, -1, f_rd, l_rd);
        chk("ff_first_read", 32'(f_rd), 32'hFF00);
        chk("ff_last_read", 32'(l_rd), 32'hFFFF);

        // Randomized transfers with spurious bus writes and occasional aborts.
        for (int r = 0; r < 8; r++) begin
            int gap;
            int inj;
            int rst_at;
            logic [15:0] ra;
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                ra = 16'($urandom_range(0, 65535));
                if (ra == TRIG) ra = 16'h4015;
                if ($urandom_range(0, 3) == 0) step(1'b0, TRIG, 8'($urandom));
                else step(1'b1, ra, 8'($urandom));
            end
            if (gap > 0) begin
                step(1'b0, 16'h0000, 8'h00);
            end
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 255)) : -1;
            rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 255)) : -1;
            ra = ($urandom_range(0, 1) == 1) ? TRIG : 16'($urandom_range(0, 65535));
            run_xfer(8'($urandom), int'($urandom_range(0, 1)), inj, ra, 8'($urandom),
                     rst_at, f_rd, l_rd);
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
